occ_lookup_arbiter: RTL and testbench

Shares one `OccDecompress` instance and one occurrence-table read port between `N_REQ` BWT-extension requesters. Each request carries a 40-bit BWT position; the block fetches the 256-bit occ block (position/32), runs the decompressor with index position%32, and returns the four 40-bit A/C/G/T counts to the winning requester. Requesters are served one at a time under round-robin arbitration. The block sits between the SMEM extension engines and the occ memory port.

---
 rtl/occ_lookup_arbiter.sv | 162 ++++++++++++++++
 tb/tb_occ_lookup_arbiter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/occ_lookup_arbiter.sv
// Round-robin arbiter sharing one occ-table read port and one OccDecompress
// instance between N_REQ BWT-extension requesters, one request in flight.
module occ_lookup_arbiter #(
  parameter int              N_REQ    = 2,
  parameter int              ADDR_W   = 32,
  parameter longint unsigned OCC_BASE = 0,
  localparam int             IDW      = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0][39:0] req_pos,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [255:0]           mem_rdata,
  output logic [255:0]           dec_block,
  output logic [4:0]             dec_i,
  output logic                   dec_start,
  input  logic [3:0][39:0]       dec_val,
  input  logic                   dec_finish,
  input  logic                   dec_busy,
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [3:0][39:0]       rsp_occ,
  input  logic                   rsp_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_DEC_START,
    S_DEC_WAIT,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [IDW-1:0]    rr_q, rr_d;
  logic [IDW-1:0]    id_q;
  logic [4:0]        pos_lo_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [255:0]      blk_q;
  logic [4:0]        dec_i_q;
  logic [3:0][39:0]  occ_q;

  logic              win_found;
  logic [IDW-1:0]    win_idx;
  logic [IDW:0]      cand;
  logic              accept;
  logic              capture;

  // First valid requester at or after rr_q, wrapping at N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N_REQ)) begin
        cand = cand - (IDW+1)'(N_REQ);
      end
      if (!win_found && req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  assign accept  = (state_q == S_IDLE) && win_found;
  assign capture = mem_rvalid &&
                   ((state_q == S_RD_WAIT) ||
                    ((state_q == S_RD_REQ) && mem_gnt));

  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + IDW'(1);
    end
  end

  assign addr_d = ADDR_W'(OCC_BASE) + ADDR_W'(req_pos[win_idx][39:5]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) state_d = S_RD_REQ;
      end
      S_RD_REQ: begin
        if (mem_gnt) begin
          state_d = mem_rvalid ? S_DEC_START : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (mem_rvalid) state_d = S_DEC_START;
      end
      S_DEC_START: begin
        if (!dec_busy) state_d = S_DEC_WAIT;
      end
      S_DEC_WAIT: begin
        if (dec_finish) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
    mem_req   = (state_q == S_RD_REQ);
    dec_start = (state_q == S_DEC_START) && !dec_busy;
    rsp_valid = (state_q == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= '0;
      id_q     <= '0;
      pos_lo_q <= '0;
      addr_q   <= '0;
      blk_q    <= '0;
      dec_i_q  <= '0;
      occ_q    <= '0;
    end else begin
      rr_q <= rr_d;
      if (accept) begin
        id_q     <= win_idx;
        pos_lo_q <= req_pos[win_idx][4:0];
        addr_q   <= addr_d;
      end
      if (capture) begin
        blk_q   <= mem_rdata;
        dec_i_q <= pos_lo_q;
      end
      if ((state_q == S_DEC_WAIT) && dec_finish) begin
        occ_q <= dec_val;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign dec_block = blk_q;
  assign dec_i     = dec_i_q;
  assign rsp_id    = id_q;
  assign rsp_occ   = occ_q;

endmodule

// File: tb/tb_occ_lookup_arbiter.sv
// Scoreboard bench for occ_lookup_arbiter with memory, decompressor
// and response-consumer models.
module tb_occ_lookup_arbiter;

  localparam int              N_REQ    = 2;
  localparam int              ADDR_W   = 32;
  localparam longint unsigned OCC_BASE = 64'h100;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0][39:0] req_pos;
  logic [N_REQ-1:0]       req_ready;
  logic                   mem_req;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_gnt;
  logic                   mem_rvalid;
  logic [255:0]           mem_rdata;
  logic [255:0]           dec_block;
  logic [4:0]             dec_i;
  logic                   dec_start;
  logic [3:0][39:0]       dec_val;
  logic                   dec_finish;
  logic                   dec_busy;
  logic                   rsp_valid;
  logic [0:0]             rsp_id;
  logic [3:0][39:0]       rsp_occ;
  logic                   rsp_ready;

  occ_lookup_arbiter #(
    .N_REQ   (N_REQ),
    .ADDR_W  (ADDR_W),
    .OCC_BASE(OCC_BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_pos   (req_pos),
    .req_ready (req_ready),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .dec_block (dec_block),
    .dec_i     (dec_i),
    .dec_start (dec_start),
    .dec_val   (dec_val),
    .dec_finish(dec_finish),
    .dec_busy  (dec_busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_occ   (rsp_occ),
    .rsp_ready (rsp_ready)
  );

  typedef struct {
    int               id;
    logic [31:0]      addr;
    logic [4:0]       i;
    logic [3:0][39:0] occ;
  } exp_t;

  typedef struct {
    int           due;
    logic [255:0] d;
  } rv_t;

  exp_t sb[$];
  rv_t  rvq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Memory content: address tag on top, four base counts below.
  function automatic logic [255:0] mem_block(input logic [31:0] a);
    logic [255:0] b;
    logic [39:0]  off;
    b          = '0;
    b[255:224] = a;
    off        = 40'(a ^ 32'(OCC_BASE + 1)) * 40'd1000;
    for (int c = 0; c < 4; c++) begin
      b[c*40 +: 40] = 40'(10 * (c + 1)) + off;
    end
    return b;
  endfunction

  function automatic logic [3:0][39:0] ref_dec(input logic [255:0] b,
                                               input logic [4:0] i);
    logic [3:0][39:0] r;
    for (int c = 0; c < 4; c++) begin
      r[c] = b[c*40 +: 40] + 40'(c + 1) * 40'(i);
    end
    return r;
  endfunction

  task automatic push_exp(input int id, input logic [39:0] pos);
    exp_t e;
    e.id   = id;
    e.addr = 32'(OCC_BASE + 64'(pos[39:5]));
    e.i    = pos[4:0];
    e.occ  = ref_dec(mem_block(e.addr), e.i);
    sb.push_back(e);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requesters: drive at negedge, drop valid once accepted.
  bit          want_v[N_REQ];
  logic [39:0] want_pos[N_REQ];

  initial begin
    req_valid = '0;
    req_pos   = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N_REQ; k++) begin
        req_valid[k] = want_v[k];
        req_pos[k]   = want_pos[k];
      end
      #2;
      for (int k = 0; k < N_REQ; k++) begin
        if (req_ready[k]) want_v[k] = 1'b0;
      end
    end
  end

  // Memory model: grant after gnt_delay held cycles, data lat cycles later.
  int gnt_delay   = 0;
  int lat         = 3;
  int held        = 0;
  bit spur_arm    = 0;
  int spur_win    = -1;
  int last_rv_win = -1;

  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (mem_req) begin
        if (held < gnt_delay) begin
          held++;
        end else begin
          mem_gnt = 1'b1;
          held    = 0;
          rvq.push_back('{cyc + lat, mem_block(mem_addr)});
        end
      end
      if (rvq.size() > 0 && rvq[0].due == cyc) begin
        mem_rvalid  = 1'b1;
        mem_rdata   = rvq[0].d;
        last_rv_win = cyc;
        void'(rvq.pop_front());
      end else if (spur_win == cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = {8{32'hDEADBEEF}};
        spur_win   = -1;
      end
      #2;
      if (spur_arm && dec_start) begin
        spur_win = cyc + 1;
        spur_arm = 0;
      end
    end
  end

  // Decompressor model: finish i+2 cycles after start.
  bit           busy_mode = 0;
  bit           dec_abort = 0;
  int           fin_win   = -1;
  int           n_ds      = 0;
  bit           prev_ds   = 0;
  logic [255:0] d_blk;
  logic [4:0]   d_i;

  initial begin
    dec_finish = 1'b0;
    dec_busy   = 1'b0;
    dec_val    = '0;
    forever begin
      @(negedge clk);
      dec_finish = 1'b0;
      dec_busy   = busy_mode && last_rv_win >= 0 &&
                   cyc >= last_rv_win + 1 && cyc <= last_rv_win + 3;
      if (fin_win == cyc) begin
        dec_finish = 1'b1;
        dec_val    = ref_dec(d_blk, d_i);
        fin_win    = -1;
      end
      #2;
      if (dec_finish) begin
        if (!dec_abort) begin
          check("dec_block_hold", dec_block, d_blk);
          check("dec_i_hold", 256'(dec_i), 256'(d_i));
        end
        dec_abort = 0;
      end
      if (dec_start && !rst) begin
        check("dec_start_1cyc", 256'(prev_ds), 256'(0));
        d_blk   = dec_block;
        d_i     = dec_i;
        fin_win = cyc + int'(dec_i) + 2;
        n_ds++;
      end
      prev_ds = dec_start;
    end
  end

  // Response consumer: hold ready low rsp_delay cycles of each response.
  int rsp_delay = 0;
  int rwait     = 0;

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (rwait < rsp_delay) begin
          rsp_ready = 1'b0;
          rwait++;
        end else begin
          rsp_ready = 1'b1;
          rwait     = 0;
        end
      end else begin
        rsp_ready = 1'b0;
      end
    end
  end

  // Monitor and scoreboard compare.
  int               exp_lat     = -1;
  int               exp_req_len = 1;
  int               exp_rsp_len = 1;
  int               exp_ds_gap  = 1;
  int               acc_win     = 0;
  int               req_len     = 0;
  int               rsp_len     = 0;
  int               n_rsp_valid = 0;
  bit               p_req       = 0;
  bit               p_rv        = 0;
  logic [31:0]      p_addr;
  logic [0:0]       p_id;
  logic [3:0][39:0] p_occ;

  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      p_req = 0;
      p_rv  = 0;
    end else begin
      if (req_ready != '0) begin
        check("ready_onehot", 256'($onehot(req_ready)), 256'(1));
        check("accept_pending", 256'(sb.size() > 0), 256'(1));
        acc_win = cyc;
        for (int k = 0; k < N_REQ; k++) begin
          if (req_ready[k] && sb.size() > 0) check("serve_order", 256'(k), 256'(sb[0].id));
        end
      end
      if (mem_req) begin
        req_len = p_req ? req_len + 1 : 1;
        if (p_req) check("addr_hold", 256'(mem_addr), 256'(p_addr));
        if (mem_gnt) begin
          check("req_len", 256'(req_len), 256'(exp_req_len));
          if (sb.size() > 0) check("mem_addr", 256'(mem_addr), 256'(sb[0].addr));
        end
      end
      p_req  = mem_req && !mem_gnt;
      p_addr = mem_addr;
      if (dec_start) begin
        check("ds_gap", 256'(cyc - last_rv_win), 256'(exp_ds_gap));
        if (sb.size() > 0) check("dec_i", 256'(dec_i), 256'(sb[0].i));
      end
      if (rsp_valid) begin
        n_rsp_valid++;
        check("ready_in_resp", 256'(req_ready), 256'(0));
        if (p_rv) begin
          check("rsp_id_hold", 256'(rsp_id), 256'(p_id));
          check("rsp_occ_hold", 256'(rsp_occ), 256'(p_occ));
        end else begin
          rsp_len = 0;
          if (exp_lat >= 0) check("latency", 256'(cyc - acc_win), 256'(exp_lat));
        end
        rsp_len++;
        if (rsp_ready) begin
          check("rsp_len", 256'(rsp_len), 256'(exp_rsp_len));
          check("rsp_pending", 256'(sb.size() > 0), 256'(1));
          if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_id", 256'(rsp_id), 256'(e.id));
            check("rsp_occ", 256'(rsp_occ), 256'(e.occ));
          end
        end
      end
      p_rv  = rsp_valid && !rsp_ready;
      p_id  = rsp_id;
      p_occ = rsp_occ;
    end
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_req_ready"}, 256'(req_ready), 256'(0));
    check({tag, "_mem_req"}, 256'(mem_req), 256'(0));
    check({tag, "_mem_addr"}, 256'(mem_addr), 256'(0));
    check({tag, "_dec_start"}, 256'(dec_start), 256'(0));
    check({tag, "_dec_block"}, dec_block, 256'(0));
    check({tag, "_dec_i"}, 256'(dec_i), 256'(0));
    check({tag, "_rsp_valid"}, 256'(rsp_valid), 256'(0));
    check({tag, "_rsp_id"}, 256'(rsp_id), 256'(0));
    check({tag, "_rsp_occ"}, 256'(rsp_occ), 256'(0));
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n;
    n = 0;
    while (sb.size() > 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_time"}, 256'(n < lim), 256'(1));
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic raise(input int k, input logic [39:0] pos);
    push_exp(k, pos);
    want_pos[k] = pos;
    want_v[k]   = 1'b1;
  endtask

  initial begin
    int n;
    int saved;
    rst = 1'b1;
    for (int k = 0; k < N_REQ; k++) begin
      want_v[k]   = 1'b0;
      want_pos[k] = '0;
    end
    repeat (3) @(negedge clk);
    #2;
    check_reset_outs("rst0");
    @(negedge clk);
    rst = 1'b0;

    // Both valid from reset, then again, then 1 alone followed by both.
    @(posedge clk);
    raise(0, 40'h00);
    raise(1, 40'h3F);
    wait_done("rr_a", 300);
    @(posedge clk);
    raise(0, 40'h00);
    raise(1, 40'h3F);
    wait_done("rr_b", 300);
    @(posedge clk);
    raise(1, 40'h3F);
    n = 0;
    while (want_v[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rr_c_accept", 256'(want_v[1]), 256'(0));
    @(posedge clk);
    raise(0, 40'h00);
    raise(1, 40'h3F);
    wait_done("rr_c", 300);

    // Single request, latency 13 with L=3 and i=5.
    exp_lat = 13;
    @(posedge clk);
    raise(0, 40'h25);
    wait_done("single", 100);
    exp_lat = -1;

    // Grant delayed four cycles plus a stray rvalid during DEC_WAIT.
    gnt_delay   = 4;
    exp_req_len = 5;
    spur_arm    = 1;
    @(posedge clk);
    raise(1, 40'h12_3456_7890);
    wait_done("gnt_delay", 200);
    gnt_delay   = 0;
    exp_req_len = 1;

    // Consumer stalls six cycles while another request is pending.
    rsp_delay   = 6;
    exp_rsp_len = 7;
    @(posedge clk);
    raise(0, 40'h1_0000);
    raise(1, 40'h2_0011);
    wait_done("rsp_hold", 300);
    rsp_delay   = 0;
    exp_rsp_len = 1;

    // Decompressor busy for three cycles on DEC_START entry.
    busy_mode  = 1;
    exp_ds_gap = 4;
    @(posedge clk);
    raise(0, 40'h47);
    wait_done("dec_busy", 200);
    busy_mode  = 0;
    exp_ds_gap = 1;

    // Reset during DEC_WAIT abandons the request.
    saved = n_ds;
    @(posedge clk);
    raise(1, 40'hFF);
    n = 0;
    while (n_ds == saved && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("rst_test_started", 256'(n_ds != saved), 256'(1));
    @(negedge clk);
    rst       = 1'b1;
    dec_abort = 1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_reset_outs("midrst");
    saved = n_rsp_valid;
    repeat (40) @(negedge clk);
    check("no_rsp_after_rst", 256'(n_rsp_valid), 256'(saved));
    @(posedge clk);
    raise(0, 40'h5A);
    wait_done("post_rst", 200);

    // Data returned in the grant cycle.
    lat     = 0;
    exp_lat = 7;
    @(posedge clk);
    raise(1, 40'h2);
    wait_done("lat0", 100);
    lat     = 3;
    exp_lat = -1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
